// File: rtl/sobel_edge_4p_if.sv
// Bus for sobel_edge_4p: window taps, valid strobe and threshold in; edge results,
// frame edge count and frame-done pulse out. No backpressure signals exist.
interface sobel_edge_4p_if #(
  parameter int PARALLEL_NUM = 4,
  parameter int DATA_WIDTH   = 8
);
  // Handshake: a beat is transferred on every clock edge where i_en is 1; o_en marks
  // a valid o_data beat. There is no ready, so the consumer must accept every beat.
  logic                                    i_en;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_11;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_12;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_13;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_21;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_22;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_23;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_31;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_32;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] i_temp_33;
  logic [DATA_WIDTH-1:0]                   i_thresh;
  logic                                    o_en;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] o_data;
  logic [31:0]                             o_edge_cnt;
  logic                                    o_frame_done;

  modport master (
    output i_en, i_temp_11, i_temp_12, i_temp_13, i_temp_21, i_temp_22, i_temp_23,
           i_temp_31, i_temp_32, i_temp_33, i_thresh,
    input  o_en, o_data, o_edge_cnt, o_frame_done
  );

  modport slave (
    input  i_en, i_temp_11, i_temp_12, i_temp_13, i_temp_21, i_temp_22, i_temp_23,
           i_temp_31, i_temp_32, i_temp_33, i_thresh,
    output o_en, o_data, o_edge_cnt, o_frame_done
  );
endinterface

// File: rtl/sobel_edge_4p.sv
// Multi-lane 3x3 Sobel edge detector, 3-stage pipeline, with per-frame edge counting.
// Define SOBEL_BINARY_OUT_EN for binary (all-ones / zero) lanes instead of magnitude.
module sobel_edge_4p #(
  parameter int PARALLEL_NUM = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int H_ACTIVE     = 1920,
  parameter int V_ACTIVE     = 1080
) (
  input logic           i_clk,
  input logic           i_rst,
  sobel_edge_4p_if.slave bus
);
  localparam int SW          = DATA_WIDTH + 2;
  localparam int GW          = DATA_WIDTH + 3;
  localparam int FRAME_BEATS = (H_ACTIVE - 2) * (V_ACTIVE - 2);
  localparam int CNT_W       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int PW          = $clog2(PARALLEL_NUM + 1);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

  function automatic logic [SW-1:0] wsum(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b,
                                         input logic [DATA_WIDTH-1:0] c);
    return SW'(a) + {1'b0, b, 1'b0} + SW'(c);
  endfunction

  logic                  v1_q, v2_q, en_q;
  logic [SW-1:0]         gx_pos_q [PARALLEL_NUM];
  logic [SW-1:0]         gx_neg_q [PARALLEL_NUM];
  logic [SW-1:0]         gy_pos_q [PARALLEL_NUM];
  logic [SW-1:0]         gy_neg_q [PARALLEL_NUM];
  logic signed [GW-1:0]  gx [PARALLEL_NUM];
  logic signed [GW-1:0]  gy [PARALLEL_NUM];
  logic [GW-1:0]         abs_gx [PARALLEL_NUM];
  logic [GW-1:0]         abs_gy [PARALLEL_NUM];
  logic [GW-1:0]         mag_d [PARALLEL_NUM];
  logic [GW-1:0]         mag_q [PARALLEL_NUM];
  logic [DATA_WIDTH-1:0] mag_sat [PARALLEL_NUM];
  logic [DATA_WIDTH-1:0] lane_d [PARALLEL_NUM];
  logic [PARALLEL_NUM-1:0] flag_d, flags_q;
  logic [PARALLEL_NUM-1:0][DATA_WIDTH-1:0] data_q;
  logic [PW-1:0]         pop;
  logic [32:0]           acc_sum;
  logic [31:0]           acc_next, acc_q, edge_cnt_q;
  logic [CNT_W-1:0]      beat_q;
  logic                  last_beat;

  // Valid chain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= bus.i_en;
      v2_q <= v1_q;
    end
  end

  // Stage 1: weighted row/column sums; Stage 2: magnitude. Data is don't-care when invalid.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < PARALLEL_NUM; k++) begin
      gx_pos_q[k] <= wsum(bus.i_temp_13[k], bus.i_temp_23[k], bus.i_temp_33[k]);
      gx_neg_q[k] <= wsum(bus.i_temp_11[k], bus.i_temp_21[k], bus.i_temp_31[k]);
      gy_pos_q[k] <= wsum(bus.i_temp_31[k], bus.i_temp_32[k], bus.i_temp_33[k]);
      gy_neg_q[k] <= wsum(bus.i_temp_11[k], bus.i_temp_12[k], bus.i_temp_13[k]);
      mag_q[k]    <= mag_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < PARALLEL_NUM; k++) begin
      gx[k]     = $signed({1'b0, gx_pos_q[k]}) - $signed({1'b0, gx_neg_q[k]});
      gy[k]     = $signed({1'b0, gy_pos_q[k]}) - $signed({1'b0, gy_neg_q[k]});
      abs_gx[k] = gx[k][GW-1] ? unsigned'(-gx[k]) : unsigned'(gx[k]);
      abs_gy[k] = gy[k][GW-1] ? unsigned'(-gy[k]) : unsigned'(gy[k]);
      mag_d[k]  = abs_gx[k] + abs_gy[k];
    end
  end

  // Stage 3 compare uses the threshold present in this cycle.
  always_comb begin
    for (int k = 0; k < PARALLEL_NUM; k++) begin
      mag_sat[k] = (mag_q[k] > GW'(PIX_MAX)) ? PIX_MAX : mag_q[k][DATA_WIDTH-1:0];
      flag_d[k]  = (mag_sat[k] >= bus.i_thresh);
`ifdef SOBEL_BINARY_OUT_EN
      lane_d[k]  = flag_d[k] ? PIX_MAX : '0;
`else
      lane_d[k]  = mag_sat[k];
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q    <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      en_q <= v2_q;
      if (v2_q) begin
        flags_q <= flag_d;
        for (int k = 0; k < PARALLEL_NUM; k++) data_q[k] <= lane_d[k];
      end
    end
  end

  // Frame accounting: accumulate popcount of each output beat, publish on the last beat.
  always_comb begin
    pop = '0;
    for (int k = 0; k < PARALLEL_NUM; k++) pop = pop + PW'(flags_q[k]);
    acc_sum   = {1'b0, acc_q} + 33'(pop);
    acc_next  = acc_sum[32] ? '1 : acc_sum[31:0];
    last_beat = (beat_q == CNT_W'(FRAME_BEATS - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q      <= '0;
      beat_q     <= '0;
      edge_cnt_q <= '0;
    end else if (en_q) begin
      if (last_beat) begin
        edge_cnt_q <= acc_next;
        acc_q      <= '0;
        beat_q     <= '0;
      end else begin
        acc_q  <= acc_next;
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign bus.o_en         = en_q;
  assign bus.o_data       = data_q;
  assign bus.o_edge_cnt   = edge_cnt_q;
  assign bus.o_frame_done = en_q && last_beat;
endmodule

// File: tb/tb_sobel_edge_4p.sv
// Directed bench for sobel_edge_4p with a 6x4 frame (8 beats per frame).
module tb_sobel_edge_4p;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [2:0] pipe;
  int   exp_beat;
  logic exp_done;

  always #5 clk = ~clk;

  sobel_edge_4p_if #(.PARALLEL_NUM(4), .DATA_WIDTH(8)) bus ();

  sobel_edge_4p #(
    .PARALLEL_NUM(4), .DATA_WIDTH(8), .H_ACTIVE(6), .V_ACTIVE(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v);
    bus.i_temp_11 = {4{v}}; bus.i_temp_12 = {4{v}}; bus.i_temp_13 = {4{v}};
    bus.i_temp_21 = {4{v}}; bus.i_temp_22 = {4{v}}; bus.i_temp_23 = {4{v}};
    bus.i_temp_31 = {4{v}}; bus.i_temp_32 = {4{v}}; bus.i_temp_33 = {4{v}};
  endtask

  task automatic set_step();
    set_all(8'hFF);
    bus.i_temp_11 = '0; bus.i_temp_21 = '0; bus.i_temp_31 = '0;
  endtask

  task automatic set_lane2(input logic [7:0] v);
    set_all(8'h00);
    bus.i_temp_13[2] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_en = 1'b0;
    step();
    step();
    rst = 1'b0;
    pipe = '0;
    exp_beat = 0;
  endtask

  // Single beat, then observe o_en three edges later
  task automatic pulse(input string tag, input logic [31:0] exp_data);
    bus.i_en = 1'b1;
    step();
    bus.i_en = 1'b0;
    check({tag, "_en_c1"}, bus.o_en, 1'b0);
    step();
    check({tag, "_en_c2"}, bus.o_en, 1'b0);
    step();
    check({tag, "_en_c3"}, bus.o_en, 1'b1);
    check({tag, "_data"}, bus.o_data, exp_data);
    step();
    check({tag, "_en_c4"}, bus.o_en, 1'b0);
    check({tag, "_hold"}, bus.o_data, exp_data);
  endtask

  // Drive i_en from pat (bit c in cycle c); track expected o_en and frame-done per cycle
  task automatic run_pattern(input logic [31:0] pat, input int n);
    for (int c = 0; c < n; c++) begin
      bus.i_en = (c < 32) ? pat[c] : 1'b0;
      step();
      pipe = {pipe[1:0], bus.i_en};
      exp_done = pipe[2] && (exp_beat == 7);
      check("o_en", bus.o_en, pipe[2]);
      check("frame_done", bus.o_frame_done, exp_done);
      if (pipe[2]) exp_beat = exp_done ? 0 : exp_beat + 1;
    end
    bus.i_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_thresh = '0;
    set_all(8'h00);
    step();
    step();
    step();
    rst = 1'b0;
    pipe = '0;
    exp_beat = 0;
    step();
    check("rst_en", bus.o_en, 1'b0);
    check("rst_data", bus.o_data, 32'h0);
    check("rst_edge_cnt", bus.o_edge_cnt, 32'h0);
    check("rst_frame_done", bus.o_frame_done, 1'b0);

    // Flat window: zero gradient, below threshold 1
    set_all(8'd100);
    bus.i_thresh = 8'd1;
`ifdef SOBEL_BINARY_OUT_EN
    pulse("flat", 32'h0000_0000);
`else
    pulse("flat", 32'h0000_0000);
`endif

    // Vertical step: Gx = 1020 saturates to 255 in every lane
    set_step();
    bus.i_thresh = 8'd128;
    pulse("step", 32'hFFFF_FFFF);

    // Lane 2 only: |Gx| = |Gy| = 10, mag 20, equal to threshold
    set_lane2(8'd10);
    bus.i_thresh = 8'd20;
`ifdef SOBEL_BINARY_OUT_EN
    pulse("lane2", 32'h00FF_0000);
`else
    pulse("lane2", 32'h0014_0000);
`endif

    // Lane 2 mag 256 just above the 8-bit range; threshold 0 flags flat lanes too
    set_lane2(8'd128);
    bus.i_thresh = 8'd0;
`ifdef SOBEL_BINARY_OUT_EN
    pulse("sat", 32'hFFFF_FFFF);
`else
    pulse("sat", 32'h00FF_0000);
`endif

    // Full frame of step beats, threshold 0: 8 beats x 4 lanes
    do_reset();
    check("frame0_cnt_reset", bus.o_edge_cnt, 32'd0);
    set_step();
    bus.i_thresh = 8'd0;
    run_pattern(32'h0000_00FF, 11);
    check("frame1_cnt", bus.o_edge_cnt, 32'd32);

    // Partial frame, then reset mid-frame, then a gapped full frame
    run_pattern(32'h0000_001F, 8);
    check("partial_hold", bus.o_edge_cnt, 32'd32);
    do_reset();
    check("after_rst_cnt", bus.o_edge_cnt, 32'd0);
    run_pattern(32'h0000_0D9B, 15);
    check("gapped_frame_cnt", bus.o_edge_cnt, 32'd32);

    // One edge lane per beat (mag == thresh counts)
    set_lane2(8'd10);
    bus.i_thresh = 8'd20;
    run_pattern(32'h0000_00FF, 11);
    check("lane2_frame_cnt", bus.o_edge_cnt, 32'd8);

    // Threshold just above mag: no edges
    bus.i_thresh = 8'd21;
    run_pattern(32'h0000_00FF, 11);
    check("no_edge_frame_cnt", bus.o_edge_cnt, 32'd0);

    // Threshold 0 counts flat windows as edges
    set_all(8'd100);
    bus.i_thresh = 8'd0;
    run_pattern(32'h0000_00FF, 11);
    check("flat_thresh0_cnt", bus.o_edge_cnt, 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
